// File: rtl/axis_char_cipher.sv
// AXI4-Stream character transformer: N byte lanes, per-packet mode/key,
// 2-entry output buffer with registered TREADY, packet/byte statistics.
`timescale 1ns/1ps
module axis_char_cipher #(
  parameter int LANES = 1,
  parameter int CNT_W = 32
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [1:0]         mode,
  input  logic [7:0]         key,
  input  logic [8*LANES-1:0] input_r_TDATA,
  input  logic [LANES-1:0]   input_r_TKEEP,
  input  logic               input_r_TLAST,
  input  logic               input_r_TVALID,
  output logic               input_r_TREADY,
  output logic [8*LANES-1:0] output_r_TDATA,
  output logic [LANES-1:0]   output_r_TKEEP,
  output logic               output_r_TLAST,
  output logic               output_r_TVALID,
  input  logic               output_r_TREADY,
  output logic [CNT_W-1:0]   pkt_count,
  output logic [CNT_W-1:0]   byte_count
);

  localparam int DW = 8 * LANES;
  localparam logic IDLE   = 1'b0;
  localparam logic IN_PKT = 1'b1;

  logic             state;
  logic [1:0]       mode_q;
  logic [7:0]       key_q;
  logic [1:0]       occ;
  logic [1:0]       occ_nxt;
  logic             tready_q;
  logic [DW-1:0]    d0, d1;
  logic [LANES-1:0] k0, k1;
  logic             l0, l1;
  logic             in_acc;
  logic             out_acc;
  logic [1:0]       eff_mode;
  logic [7:0]       eff_key;
  logic [DW-1:0]    xdata;
  logic [CNT_W-1:0] pop;

  function automatic logic [7:0] xform(
    input logic [1:0] m,
    input logic [7:0] k,
    input logic [7:0] c
  );
    logic [4:0] s;
    logic [5:0] t;
    logic [7:0] r;
    logic       lower;
    logic       upper;
    s = (k[4:0] >= 5'd26) ? k[4:0] - 5'd26 : k[4:0];
    lower = (c >= 8'h61) && (c <= 8'h7a);
    upper = (c >= 8'h41) && (c <= 8'h5a);
    t = 6'd0;
    r = c;
    case (m)
      2'd1: begin
        if (lower || upper) begin
          t = 6'(c - (lower ? 8'h61 : 8'h41)) + 6'(s);
          if (t >= 6'd26) t = t - 6'd26;
          r = (lower ? 8'h61 : 8'h41) + 8'(t);
        end
      end
      2'd2: r = c ^ k;
      2'd3: r = (lower || upper) ? (c ^ 8'h20) : c;
      default: r = c;
    endcase
    return r;
  endfunction

  assign in_acc  = input_r_TVALID && tready_q;
  assign out_acc = (occ != 2'd0) && output_r_TREADY;

  // First beat of a packet uses the live controls; later beats the latched pair.
  assign eff_mode = (state == IDLE) ? mode : mode_q;
  assign eff_key  = (state == IDLE) ? key  : key_q;

  always_comb begin
    xdata = '0;
    for (int i = 0; i < LANES; i++) begin
      if (input_r_TKEEP[i])
        xdata[8*i +: 8] = xform(eff_mode, eff_key, input_r_TDATA[8*i +: 8]);
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++)
      pop = pop + CNT_W'(k0[i]);
  end

  always_comb begin
    occ_nxt = occ;
    if (in_acc && !out_acc)      occ_nxt = occ + 2'd1;
    else if (!in_acc && out_acc) occ_nxt = occ - 2'd1;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      mode_q     <= '0;
      key_q      <= '0;
      occ        <= '0;
      tready_q   <= 1'b0;
      d0         <= '0;
      d1         <= '0;
      k0         <= '0;
      k1         <= '0;
      l0         <= 1'b0;
      l1         <= 1'b0;
      pkt_count  <= '0;
      byte_count <= '0;
    end else begin
      if (in_acc && state == IDLE) begin
        mode_q <= mode;
        key_q  <= key;
      end
      if (in_acc)
        state <= input_r_TLAST ? IDLE : IN_PKT;
      if (out_acc) begin
        if (occ == 2'd2) begin
          d0 <= d1;
          k0 <= k1;
          l0 <= l1;
        end else if (in_acc) begin
          d0 <= xdata;
          k0 <= input_r_TKEEP;
          l0 <= input_r_TLAST;
        end
      end else if (in_acc) begin
        if (occ == 2'd0) begin
          d0 <= xdata;
          k0 <= input_r_TKEEP;
          l0 <= input_r_TLAST;
        end else begin
          d1 <= xdata;
          k1 <= input_r_TKEEP;
          l1 <= input_r_TLAST;
        end
      end
      occ      <= occ_nxt;
      tready_q <= (occ_nxt != 2'd2);
      if (out_acc) begin
        byte_count <= byte_count + pop;
        if (l0) pkt_count <= pkt_count + 1'b1;
      end
    end
  end

  assign input_r_TREADY  = tready_q;
  assign output_r_TVALID = (occ != 2'd0);
  assign output_r_TDATA  = d0;
  assign output_r_TKEEP  = k0;
  assign output_r_TLAST  = l0;

endmodule

// File: tb/tb_axis_char_cipher.sv
// Bench for axis_char_cipher (LANES=4): queue-based reference model,
// per-cycle compare process, directed literal cases and random traffic.
`timescale 1ns/1ps
module tb_axis_char_cipher;

  logic        ap_clk = 0;
  logic        ap_rst_n = 0;
  logic [1:0]  mode = 0;
  logic [7:0]  key = 0;
  logic [31:0] input_r_TDATA = 0;
  logic [3:0]  input_r_TKEEP = 0;
  logic        input_r_TLAST = 0;
  logic        input_r_TVALID = 0;
  logic        input_r_TREADY;
  logic [31:0] output_r_TDATA;
  logic [3:0]  output_r_TKEEP;
  logic        output_r_TLAST;
  logic        output_r_TVALID;
  logic        output_r_TREADY = 1;
  logic [31:0] pkt_count;
  logic [31:0] byte_count;

  axis_char_cipher #(.LANES(4), .CNT_W(32)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .mode(mode), .key(key),
    .input_r_TDATA(input_r_TDATA), .input_r_TKEEP(input_r_TKEEP),
    .input_r_TLAST(input_r_TLAST), .input_r_TVALID(input_r_TVALID),
    .input_r_TREADY(input_r_TREADY),
    .output_r_TDATA(output_r_TDATA), .output_r_TKEEP(output_r_TKEEP),
    .output_r_TLAST(output_r_TLAST), .output_r_TVALID(output_r_TVALID),
    .output_r_TREADY(output_r_TREADY),
    .pkt_count(pkt_count), .byte_count(byte_count)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  int          n_tests = 0;
  int          n_fail = 0;
  beat_t       q[$];
  logic        m_in_pkt = 0;
  int          m_mode = 0;
  int          m_key = 0;
  logic [31:0] m_pkt = 0;
  logic [31:0] m_byte = 0;
  logic        prev_rst = 0;
  logic        stall = 0;
  beat_t       held;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_xf(input int m, input int k, input int c);
    int s;
    s = (k % 32) % 26;
    if (m == 1) begin
      if (c >= 97 && c <= 122) return 8'(((c - 97 + s) % 26) + 97);
      if (c >= 65 && c <= 90)  return 8'(((c - 65 + s) % 26) + 65);
      return 8'(c);
    end
    if (m == 2) return 8'(c ^ k);
    if (m == 3) begin
      if ((c >= 97 && c <= 122) || (c >= 65 && c <= 90)) return 8'(c ^ 32);
      return 8'(c);
    end
    return 8'(c);
  endfunction

  function automatic int popc(input logic [3:0] k);
    return int'(k[0]) + int'(k[1]) + int'(k[2]) + int'(k[3]);
  endfunction

  // Reference model and per-cycle comparison
  always @(negedge ap_clk) begin
    beat_t e;
    if (!ap_rst_n) begin
      q.delete();
      m_in_pkt = 0;
      m_pkt = 0;
      m_byte = 0;
      stall = 0;
      prev_rst = 0;
    end else begin
      if (prev_rst) begin
        chk("tready", {63'd0, input_r_TREADY}, {63'd0, q.size() < 2});
        chk("tvalid", {63'd0, output_r_TVALID}, {63'd0, q.size() != 0});
        chk("pkt_count", {32'd0, pkt_count}, {32'd0, m_pkt});
        chk("byte_count", {32'd0, byte_count}, {32'd0, m_byte});
        if (stall) begin
          chk("hold_data", {32'd0, output_r_TDATA}, {32'd0, held.d});
          chk("hold_keep", {60'd0, output_r_TKEEP}, {60'd0, held.k});
          chk("hold_last", {63'd0, output_r_TLAST}, {63'd0, held.l});
        end
        if (output_r_TVALID && output_r_TREADY) begin
          if (q.size() == 0) begin
            chk("spurious_beat", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk("out_data", {32'd0, output_r_TDATA}, {32'd0, e.d});
            chk("out_keep", {60'd0, output_r_TKEEP}, {60'd0, e.k});
            chk("out_last", {63'd0, output_r_TLAST}, {63'd0, e.l});
            m_byte = m_byte + 32'(popc(e.k));
            if (e.l) m_pkt = m_pkt + 1;
          end
        end
        stall = output_r_TVALID && !output_r_TREADY;
        held.d = output_r_TDATA;
        held.k = output_r_TKEEP;
        held.l = output_r_TLAST;
        if (input_r_TVALID && input_r_TREADY) begin
          if (!m_in_pkt) begin
            m_mode = int'(mode);
            m_key = int'(key);
          end
          for (int i = 0; i < 4; i++)
            e.d[8*i +: 8] = input_r_TKEEP[i] ?
              m_xf(m_mode, m_key, int'(input_r_TDATA[8*i +: 8])) : 8'h00;
          e.k = input_r_TKEEP;
          e.l = input_r_TLAST;
          q.push_back(e);
          m_in_pkt = !input_r_TLAST;
        end
      end
      prev_rst = 1;
    end
  end

  task automatic send(input logic [1:0] m, input logic [7:0] k,
                      input logic [31:0] d, input logic [3:0] kp,
                      input logic l);
    int t;
    @(posedge ap_clk); #1;
    mode = m;
    key = k;
    input_r_TDATA = d;
    input_r_TKEEP = kp;
    input_r_TLAST = l;
    input_r_TVALID = 1;
    t = 0;
    forever begin
      @(negedge ap_clk);
      if (input_r_TREADY) break;
      t++;
      if (t > 100) begin
        chk("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge ap_clk); #1;
    input_r_TVALID = 0;
  endtask

  task automatic do_reset();
    @(posedge ap_clk); #1;
    ap_rst_n = 0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_tvalid", {63'd0, output_r_TVALID}, 64'd0);
    chk("rst_tdata", {32'd0, output_r_TDATA}, 64'd0);
    chk("rst_tkeep", {60'd0, output_r_TKEEP}, 64'd0);
    chk("rst_tlast", {63'd0, output_r_TLAST}, 64'd0);
    chk("rst_tready", {63'd0, input_r_TREADY}, 64'd0);
    chk("rst_pkt", {32'd0, pkt_count}, 64'd0);
    chk("rst_byte", {32'd0, byte_count}, 64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1;
  endtask

  logic [31:0] c_b;
  logic [31:0] c_p;
  logic        rnd_done;

  initial begin
    output_r_TREADY = 1;
    do_reset();

    // 'h' + 3 -> 'k'
    send(2'd1, 8'd3, 32'h00000068, 4'h1, 1'b1);
    @(negedge ap_clk);
    chk("caesar_h", {32'd0, output_r_TDATA}, 64'h6b);
    chk("caesar_last", {63'd0, output_r_TLAST}, 64'd1);
    @(negedge ap_clk);
    chk("first_pkt", {32'd0, pkt_count}, 64'd1);
    chk("first_byte", {32'd0, byte_count}, 64'd1);

    // key 27 -> shift 1, wraps z/Z, digit untouched, lane 3 dropped
    send(2'd1, 8'd27, 32'h71355A7A, 4'h7, 1'b1);
    @(negedge ap_clk);
    chk("caesar_wrap", {32'd0, output_r_TDATA}, 64'h00354161);

    repeat (2) @(negedge ap_clk);
    c_b = byte_count;
    c_p = pkt_count;
    send(2'd3, 8'd0, 32'h6F4C6548, 4'hF, 1'b0);
    @(negedge ap_clk);
    chk("case_beat1", {32'd0, output_r_TDATA}, 64'h4F6C4568);
    send(2'd3, 8'd0, 32'h55AA7821, 4'h3, 1'b1);
    @(negedge ap_clk);
    chk("case_beat2", {32'd0, output_r_TDATA}, 64'h00005821);
    @(negedge ap_clk);
    chk("case_bytes", {32'd0, byte_count - c_b}, 64'd6);
    chk("case_pkts", {32'd0, pkt_count - c_p}, 64'd1);

    // back-pressure: five beats against a stalled sink
    output_r_TREADY = 0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(2'd2, 8'h0F, 32'h01020304 * (i + 1), 4'hF, i == 4);
      end
      begin
        repeat (12) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("bp_tready_low", {63'd0, input_r_TREADY}, 64'd0);
        chk("bp_tvalid_high", {63'd0, output_r_TVALID}, 64'd1);
        @(posedge ap_clk); #1;
        output_r_TREADY = 1;
      end
    join
    repeat (6) @(posedge ap_clk);

    // controls changed mid-packet must not affect it
    send(2'd2, 8'hFF, 32'h11111111, 4'hF, 1'b0);
    send(2'd0, 8'h00, 32'h12345678, 4'hF, 1'b0);
    @(negedge ap_clk);
    chk("latch_xor", {32'd0, output_r_TDATA}, 64'hEDCBA987);
    send(2'd0, 8'h00, 32'hAAAAAAAA, 4'hF, 1'b1);
    send(2'd0, 8'h00, 32'h41424344, 4'hF, 1'b1);
    @(negedge ap_clk);
    chk("latch_next_pkt", {32'd0, output_r_TDATA}, 64'h41424344);

    // random traffic with random sink stalls
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) @(posedge ap_clk);
          send(2'($urandom), 8'($urandom), $urandom, 4'($urandom),
               $urandom_range(3) == 0);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge ap_clk); #1;
          output_r_TREADY = $urandom_range(1);
        end
      end
    join
    @(posedge ap_clk); #1;
    output_r_TREADY = 1;
    repeat (6) @(posedge ap_clk);
    chk("drain", 64'(q.size()), 64'd0);

    // reset with two beats buffered
    output_r_TREADY = 0;
    send(2'd2, 8'h5A, 32'h61626364, 4'hF, 1'b0);
    send(2'd2, 8'h5A, 32'h65666768, 4'hF, 1'b0);
    @(negedge ap_clk);
    chk("pre_rst_full", {63'd0, input_r_TREADY}, 64'd0);
    do_reset();
    output_r_TREADY = 1;
    send(2'd1, 8'd1, 32'h00000061, 4'h1, 1'b1);
    @(negedge ap_clk);
    chk("post_rst_fresh", {32'd0, output_r_TDATA}, 64'h62);
    @(negedge ap_clk);
    chk("post_rst_pkt", {32'd0, pkt_count}, 64'd1);
    repeat (3) @(posedge ap_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
